id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-stage front end and ID/EX pipeline register for the 5-stage RISC-V (RV32I) pipeline.
- Drives the register file read addresses from the IF/ID instruction.
- Captures the two read operands, with an internal WB-to-ID bypass.
- Generates the immediate and the control bits.
- Detects load-use hazards, and registers everything into EX under stall, hold and flush control.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
NOP_INSTR, 32'h00000013, instruction word placed in ex_instr for bubbles and after reset (addi x0,x0,0).

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  synchronous, active-high; clears all ID/EX state
id_valid  in  1  IF/ID holds a real instruction
id_pc  in  32  PC of the IF/ID instruction
id_instr  in  32  IF/ID instruction word
rf_rs1  out  5  register file ReadRegister1 = id_instr[19:15], combinational
rf_rs2  out  5  register file ReadRegister2 = id_instr[24:20], combinational
rf_rd1  in  32  register file ReadData1
rf_rd2  in  32  register file ReadData2
wb_regwrite  in  1  WB stage write enable (same signal as register file RegWrite)
wb_rd  in  5  WB destination (same as WriteRegister)
wb_data  in  32  WB result (same as WriteData)
ex_flush  in  1  branch/jump resolved taken in EX; kill ID/EX contents
ex_hold  in  1  downstream multi-cycle stall; freeze ID/EX
id_stall  out  1  combinational; IF and IF/ID must hold when 1
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  32  registered id_pc
ex_instr  out  32  registered instruction word (NOP_INSTR when bubble)
ex_rs1_val  out  32  registered rs1 operand after bypass
ex_rs2_val  out  32  registered rs2 operand after bypass
ex_imm  out  32  registered sign-extended immediate
ex_rd  out  5  destination register, forced 0 when not writing
ex_rs1  out  5  source 1 index, forced 0 when rs1 unused (for EX forwarding)
ex_rs2  out  5  source 2 index, forced 0 when rs2 unused
ex_regwrite  out  1  instruction writes rd
ex_memread  out  1  LOAD
ex_memwrite  out  1  STORE
ex_illegal  out  1  unrecognised opcode with id_valid=1

Behaviour:
- Reset, synchronous: every ex_* output is 0 except ex_instr=NOP_INSTR. id_stall is combinational and not itself reset, but evaluates to 0 after reset because ex_valid=0.
- Decode by opcode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111: regwrite=1.
  - JALR 1100111: regwrite=1, uses rs1.
  - BRANCH 1100011: uses rs1 and rs2.
  - LOAD 0000011: regwrite=1, memread=1, uses rs1.
  - STORE 0100011: memwrite=1, uses rs1 and rs2.
  - OP-IMM 0010011: regwrite=1, uses rs1.
  - OP 0110011: regwrite=1, uses rs1 and rs2.
  - Any other opcode: all controls 0, illegal=1.
  - rd==0 forces regwrite=0 and ex_rd=0.
- Immediate, sign bit instr[31]:
  - I: {20{i31}, instr[31:20]}.
  - S: {20{i31}, instr[31:25], instr[11:7]}.
  - B: {19{i31}, i31, instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {11{i31}, i31, instr[19:12], instr[20], instr[30:21], 0}.
  - OP and illegal: imm=0.
- Bypass: if wb_regwrite && wb_rd!=0 && wb_rd==rf_rs1, the captured operand is wb_data, otherwise rf_rd1. rs2 is handled the same way. Index 0 always yields 0 regardless of wb.
- Load-use: id_stall = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((rs1 used & ex_rd==rf_rs1) | (rs2 used & ex_rd==rf_rs2)) & ~ex_flush & ~ex_hold. The block adds exactly one bubble per load-use pair.
- Update priority each rising edge:
  1. reset.
  2. ex_flush: load bubble (ex_valid=0, all controls 0, ex_instr=NOP_INSTR). Flush overrides hold.
  3. ex_hold: all ID/EX registers keep their value.
  4. id_stall: load bubble.
  5. Otherwise: capture decoded ID contents, with ex_valid=id_valid.
- When id_valid=0, the capture stores ex_valid=0 and all control bits 0; data fields are don't-care but must be deterministic.
- Latency: exactly 1 cycle from IF/ID to ID/EX.
- No combinational path from any ex_* input to ex_* outputs.

Test Plan:
- Reset held 2 cycles with id_valid=1 -> ex_valid=0, ex_instr=32'h00000013, ex_regwrite=0, id_stall=0. Release -> the next edge captures the instruction.
- Capture "addi x5,x1,-4" (32'hFFC08293) with rf_rd1=10 -> after 1 edge: ex_rs1_val=10, ex_imm=32'hFFFFFFFC, ex_rd=5, ex_rs1=1, ex_rs2=0, ex_regwrite=1.
- Bypass: ID "add x3,x4,x4" while wb_regwrite=1, wb_rd=4, wb_data=0x1234, rf_rd1/rf_rd2=0 -> ex_rs1_val=ex_rs2_val=0x1234. The same case with wb_rd=0 -> both 0.
- Load-use: EX holds "lw x6,0(x2)", ID holds "add x7,x6,x1" -> id_stall=1 for one cycle and the next ID/EX is a bubble. The cycle after, id_stall=0 and the add is captured. Same test with "sw x6,0(x2)" in ID -> stall also asserts, because rs2 is used.
- Flush with hold: ex_flush=1 and ex_hold=1 together -> ex_valid=0. Hold alone for 3 cycles -> all ex_* outputs stable and id_stall=0.
- Immediates and illegal: BEQ with offset -8 -> ex_imm=32'hFFFFFFF8. JAL with +2048 -> ex_imm=32'h00000800. LUI 0xABCDE -> ex_imm=32'hABCDE000. Opcode 1111111 -> ex_illegal=1, ex_regwrite=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID stage front end and ID/EX pipeline register for the RV32I 5-stage pipeline.
// Decodes the IF/ID instruction, reads operands with a WB->ID bypass, detects
// load-use hazards and registers the result into EX under flush/hold/stall.
module id_ex_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            illegal;
  } idex_t;

  idex_t idex_q, idex_d;

  logic [6:0]      opcode;
  logic [4:0]      rd_fld;
  logic            i31;
  logic            dec_rw, dec_mr, dec_mw, dec_use1, dec_use2, dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] op1, op2;

  assign opcode = id_instr[6:0];
  assign rd_fld = id_instr[11:7];
  assign i31    = id_instr[31];
  assign rf_rs1 = id_instr[19:15];
  assign rf_rs2 = id_instr[24:20];

  // Opcode decode: control bits, source usage and immediate format.
  always_comb begin
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_ill  = 1'b0;
    dec_imm  = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_rw  = 1'b1;
        dec_imm = {id_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_rw  = 1'b1;
        dec_imm = {{11{i31}}, i31, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_OPIMM: begin
        dec_rw   = 1'b1;
        dec_use1 = 1'b1;
        dec_imm  = {{20{i31}}, id_instr[31:20]};
      end
      OPC_BRANCH: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_imm  = {{19{i31}}, i31, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        dec_rw   = 1'b1;
        dec_mr   = 1'b1;
        dec_use1 = 1'b1;
        dec_imm  = {{20{i31}}, id_instr[31:20]};
      end
      OPC_STORE: begin
        dec_mw   = 1'b1;
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_imm  = {{20{i31}}, id_instr[31:25], id_instr[11:7]};
      end
      OPC_OP: begin
        dec_rw   = 1'b1;
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so treat them as non-writing.
    if (rd_fld == 5'd0) dec_rw = 1'b0;
  end

  // WB->ID bypass covers the register file's write-then-read in the same cycle.
  always_comb begin
    if (rf_rs1 == 5'd0)                          op1 = '0;
    else if (wb_regwrite && (wb_rd == rf_rs1))   op1 = wb_data;
    else                                         op1 = rf_rd1;
    if (rf_rs2 == 5'd0)                          op2 = '0;
    else if (wb_regwrite && (wb_rd == rf_rs2))   op2 = wb_data;
    else                                         op2 = rf_rd2;
  end

  assign id_stall = idex_q.valid & idex_q.memread & (idex_q.rd != 5'd0) & id_valid &
                    ((dec_use1 & (idex_q.rd == rf_rs1)) | (dec_use2 & (idex_q.rd == rf_rs2))) &
                    ~ex_flush & ~ex_hold;

  // Next ID/EX contents: flush beats hold, hold beats stall, otherwise capture.
  always_comb begin
    idex_d = idex_q;
    if (ex_flush || (!ex_hold && id_stall)) begin
      idex_d       = '0;
      idex_d.instr = NOP_INSTR;
    end else if (!ex_hold) begin
      idex_d.valid    = id_valid;
      idex_d.pc       = id_pc;
      idex_d.instr    = id_valid ? id_instr : NOP_INSTR;
      idex_d.rs1_val  = op1;
      idex_d.rs2_val  = op2;
      idex_d.imm      = dec_imm;
      idex_d.rd       = (id_valid && dec_rw) ? rd_fld : 5'd0;
      idex_d.rs1      = (id_valid && dec_use1) ? rf_rs1 : 5'd0;
      idex_d.rs2      = (id_valid && dec_use2) ? rf_rs2 : 5'd0;
      idex_d.regwrite = id_valid & dec_rw;
      idex_d.memread  = id_valid & dec_mr;
      idex_d.memwrite = id_valid & dec_mw;
      idex_d.illegal  = id_valid & dec_ill;
    end
  end

  // ID/EX register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q       <= '0;
      idex_q.instr <= NOP_INSTR;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_instr    = idex_q.instr;
  assign ex_rs1_val  = idex_q.rs1_val;
  assign ex_rs2_val  = idex_q.rs2_val;
  assign ex_imm      = idex_q.imm;
  assign ex_rd       = idex_q.rd;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes cycle-tagged expectations,
// a monitor on the falling edge pops and compares them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush, ex_hold, id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_illegal;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_ex;
    bit          full;
    bit          ck_instr;
    string       name;
    logic        stall;
    logic        valid;
    logic [31:0] pc, instr, v1, v2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mr, mw, ill;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Cycle counter used to tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t mk_rec(input string n, input logic [31:0] pc, ins, v1, v2, imm,
                                  input logic [4:0] rd, rs1, rs2,
                                  input logic rw, mr, mw, ill);
    exp_t e;
    e.name = n; e.full = 1; e.ck_instr = 1; e.valid = 1;
    e.pc = pc; e.instr = ins; e.v1 = v1; e.v2 = v2; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t mk_bub(input string n, input bit full, input bit ck_instr);
    exp_t e;
    e = mk_rec(n, 32'h0, 32'h00000013, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    e.valid = 0; e.full = full; e.ck_instr = ck_instr;
    return e;
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          exp_t e;
          e = sb[i];
          if (!e.is_ex) begin
            chk({e.name, ".id_stall"}, {31'b0, id_stall}, {31'b0, e.stall});
          end else begin
            chk({e.name, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
            if (e.ck_instr) chk({e.name, ".ex_instr"}, ex_instr, e.instr);
            chk({e.name, ".ex_rd"}, {27'b0, ex_rd}, {27'b0, e.rd});
            chk({e.name, ".ex_rs1"}, {27'b0, ex_rs1}, {27'b0, e.rs1});
            chk({e.name, ".ex_rs2"}, {27'b0, ex_rs2}, {27'b0, e.rs2});
            chk({e.name, ".ctrl"}, {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_illegal},
                {28'b0, e.rw, e.mr, e.mw, e.ill});
            if (e.full) begin
              chk({e.name, ".ex_pc"}, ex_pc, e.pc);
              chk({e.name, ".ex_rs1_val"}, ex_rs1_val, e.v1);
              chk({e.name, ".ex_rs2_val"}, ex_rs2_val, e.v2);
              chk({e.name, ".ex_imm"}, ex_imm, e.imm);
            end
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic set_id(input logic v, input logic [31:0] pc, ins, d1, d2);
    id_valid = v; id_pc = pc; id_instr = ins; rf_rd1 = d1; rf_rd2 = d2;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] rd, input logic [31:0] d);
    wb_regwrite = w; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_ctl(input logic f, input logic h);
    ex_flush = f; ex_hold = h;
  endtask

  // Push stall expectation for the current inputs and the ID/EX expectation
  // for after the next rising edge, then advance one cycle.
  task automatic step(input string n, input logic s, input exp_t e);
    exp_t st;
    if (cyc > 0) begin
      st = mk_bub(n, 0, 0);
      st.cyc = cyc; st.is_ex = 0; st.stall = s;
      sb.push_back(st);
    end
    e.cyc = cyc + 1; e.is_ex = 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LW  = 32'h00012303;  // lw  x6,0(x2)
  localparam logic [31:0] ADD = 32'h001303B3;  // add x7,x6,x1

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_ctl(0, 0);
    set_wb(0, 5'd0, 32'h0);
    set_id(1, 32'h100, 32'hFFC08293, 32'd10, 32'h0);
    step("rst0", 0, mk_bub("rst0", 1, 1));
    step("rst1", 0, mk_bub("rst1", 1, 1));
    reset = 1'b0;
    step("addi", 0, mk_rec("addi", 32'h100, 32'hFFC08293, 32'd10, 32'h0, 32'hFFFFFFFC,
                           5'd5, 5'd1, 5'd0, 1, 0, 0, 0));

    set_id(1, 32'h104, 32'h004201B3, 32'h0, 32'h0); set_wb(1, 5'd4, 32'h1234);
    step("byp", 0, mk_rec("byp", 32'h104, 32'h004201B3, 32'h1234, 32'h1234, 32'h0,
                          5'd3, 5'd4, 5'd4, 1, 0, 0, 0));
    set_id(1, 32'h108, 32'h004201B3, 32'h0, 32'h0); set_wb(1, 5'd0, 32'h1234);
    step("byp_rd0", 0, mk_rec("byp_rd0", 32'h108, 32'h004201B3, 32'h0, 32'h0, 32'h0,
                              5'd3, 5'd4, 5'd4, 1, 0, 0, 0));
    set_id(1, 32'h10C, 32'h00500093, 32'h55, 32'h77); set_wb(1, 5'd0, 32'h999);
    step("x0_src", 0, mk_rec("x0_src", 32'h10C, 32'h00500093, 32'h0, 32'h77, 32'h5,
                             5'd1, 5'd0, 5'd0, 1, 0, 0, 0));
    set_wb(0, 5'd0, 32'h0);

    set_id(1, 32'h110, LW, 32'h2000, 32'h0);
    step("lw", 0, mk_rec("lw", 32'h110, LW, 32'h2000, 32'h0, 32'h0, 5'd6, 5'd2, 5'd0, 1, 1, 0, 0));
    set_id(1, 32'h114, ADD, 32'h66, 32'h11);
    step("lu_add", 1, mk_bub("lu_add_bub", 0, 1));
    step("lu_add2", 0, mk_rec("add", 32'h114, ADD, 32'h66, 32'h11, 32'h0,
                              5'd7, 5'd6, 5'd1, 1, 0, 0, 0));
    set_id(1, 32'h118, LW, 32'h2000, 32'h0);
    step("lw2", 0, mk_rec("lw2", 32'h118, LW, 32'h2000, 32'h0, 32'h0, 5'd6, 5'd2, 5'd0, 1, 1, 0, 0));
    set_id(1, 32'h11C, 32'h00612023, 32'h2000, 32'h66);
    step("lu_sw", 1, mk_bub("lu_sw_bub", 0, 1));
    step("lu_sw2", 0, mk_rec("sw", 32'h11C, 32'h00612023, 32'h2000, 32'h66, 32'h0,
                             5'd0, 5'd2, 5'd6, 0, 0, 1, 0));

    set_id(1, 32'h120, 32'hFE208CE3, 32'h1, 32'h2);
    step("beq", 0, mk_rec("beq", 32'h120, 32'hFE208CE3, 32'h1, 32'h2, 32'hFFFFFFF8,
                          5'd0, 5'd1, 5'd2, 0, 0, 0, 0));
    set_id(1, 32'h124, LW, 32'h2000, 32'h0);
    step("lw3", 0, mk_rec("lw3", 32'h124, LW, 32'h2000, 32'h0, 32'h0, 5'd6, 5'd2, 5'd0, 1, 1, 0, 0));
    set_id(1, 32'h128, ADD, 32'h66, 32'h11); set_ctl(0, 1);
    for (int i = 0; i < 3; i++)
      step("hold", 0, mk_rec("hold", 32'h124, LW, 32'h2000, 32'h0, 32'h0,
                             5'd6, 5'd2, 5'd0, 1, 1, 0, 0));
    set_ctl(1, 1);
    step("flush_hold", 0, mk_bub("flush_hold", 0, 1));
    set_ctl(0, 0);
    step("add2", 0, mk_rec("add2", 32'h128, ADD, 32'h66, 32'h11, 32'h0,
                           5'd7, 5'd6, 5'd1, 1, 0, 0, 0));

    set_id(1, 32'h12C, 32'h001000EF, 32'h0, 32'h22);
    step("jal", 0, mk_rec("jal", 32'h12C, 32'h001000EF, 32'h0, 32'h22, 32'h00000800,
                          5'd1, 5'd0, 5'd0, 1, 0, 0, 0));
    set_id(1, 32'h130, 32'hABCDE537, 32'h33, 32'h44);
    step("lui", 0, mk_rec("lui", 32'h130, 32'hABCDE537, 32'h33, 32'h44, 32'hABCDE000,
                          5'd10, 5'd0, 5'd0, 1, 0, 0, 0));
    set_id(1, 32'h134, 32'h00000FFF, 32'h5, 32'h6);
    step("illegal", 0, mk_rec("illegal", 32'h134, 32'h00000FFF, 32'h0, 32'h0, 32'h0,
                              5'd0, 5'd0, 5'd0, 0, 0, 0, 1));
    set_id(0, 32'h138, 32'h00000FFF, 32'h0, 32'h0);
    step("inv_ill", 0, mk_bub("inv_ill", 0, 0));
    set_id(1, 32'h13C, 32'h00100013, 32'h0, 32'h0);
    step("rd0", 0, mk_rec("rd0", 32'h13C, 32'h00100013, 32'h0, 32'h0, 32'h1,
                          5'd0, 5'd0, 5'd0, 0, 0, 0, 0));
    set_id(1, 32'h140, LW, 32'h2000, 32'h0);
    step("lw4", 0, mk_rec("lw4", 32'h140, LW, 32'h2000, 32'h0, 32'h0, 5'd6, 5'd2, 5'd0, 1, 1, 0, 0));
    set_id(0, 32'h144, ADD, 32'h66, 32'h11);
    step("inv_dep", 0, mk_bub("inv_dep", 0, 0));
    step("idle", 0, mk_bub("idle", 0, 0));

    @(negedge clk);
    #1;
    chk("sb_leftover", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
